wb_ram_burst: RTL and testbench

- Synthesizable Wishbone B3 slave RAM on the SoC data/instruction bus, downstream of the mor1kx bus arbiter.
- Replaces the behavioural memory model in the generic system.
- Serves classic single-beat cycles and CTI/BTE incrementing bursts at one beat per clock after the first.
- Keeps a word-indexed array that the bench preloads (ELF, clear_ram) through the hierarchical path `<inst>.ram0.mem[i]`.

---
 rtl/wb_ram_burst_pkg.sv | 33 +++
 rtl/wb_ram_burst_mem.sv | 39 +++
 rtl/wb_ram_burst.sv | 125 ++++++++++++
 tb/tb_wb_ram_burst.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_burst_pkg.sv
// Shared Wishbone encodings, controller states and burst address stepping.
package wb_ram_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST,
    ERR
  } state_e;

  // Word address of the next beat; wrap modes only step the low bits.
  function automatic logic [31:0] next_burst_adr(input logic [31:0] adr, input logic [1:0] bte);
    logic [31:0] r;
    r = adr;
    case (bte)
      BTE_LINEAR: r = adr + 32'd1;
      BTE_WRAP4:  r[1:0] = adr[1:0] + 2'd1;
      BTE_WRAP8:  r[2:0] = adr[2:0] + 3'd1;
      default:    r[3:0] = adr[3:0] + 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_ram_burst_mem.sv
// Word-organised RAM: synchronous read, byte-masked synchronous write.
module wb_ram_burst_mem
  import wb_ram_burst_pkg::*;
#(
  parameter int unsigned WW      = 23,
  parameter              MEMFILE = ""
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rd_en,
  input  logic [WW-1:0] i_rd_adr,
  input  logic          i_wr_en,
  input  logic [WW-1:0] i_wr_adr,
  input  logic [31:0]   i_wr_dat,
  input  logic [3:0]    i_wr_sel,
  output logic [31:0]   o_rd_dat
);

  logic [31:0] mem [0:(2**WW)-1];
  logic [31:0] r_rd_dat;

  // Byte-lane write; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_wr_sel[b]) mem[i_wr_adr][8*b +: 8] <= i_wr_dat[8*b +: 8];
      end
    end
  end

  // Read register holds its value whenever no read is requested.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_dat <= '0;
    else if (i_rd_en) r_rd_dat <= mem[i_rd_adr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B3 RAM slave with classic cycles and CTI/BTE incrementing bursts.
module wb_ram_burst
  import wb_ram_burst_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 32'h02000000,
  parameter              MEMFILE  = "",
  parameter int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned WW = AW - 2;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [WW-1:0] r_adr;
  logic [WW-1:0] w_adr_nxt;
  logic [WW-1:0] w_rd_adr;
  logic          w_rd_en;
  logic          w_wr_en;
  logic          w_req;
  logic          w_in_range;
  logic          w_last;
  logic [31:0]   w_inc;
  logic          w_unused_inc;

  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_in_range   = ({1'b0, wb_adr_i} < 33'(MEM_SIZE));
  assign w_last       = (wb_cti_i == CTI_EOB) || (wb_cti_i == CTI_CLASSIC);
  assign w_inc        = next_burst_adr(32'(r_adr), wb_bte_i);
  assign w_unused_inc = ^w_inc[31:WW];

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (!w_in_range)            w_state_nxt = ERR;
          else if (wb_cti_i == CTI_INC) w_state_nxt = BURST;
          else                        w_state_nxt = CLASSIC;
        end
      end
      CLASSIC: w_state_nxt = IDLE;
      BURST: begin
        if (!wb_cyc_i)                w_state_nxt = IDLE;
        else if (wb_stb_i && w_last)  w_state_nxt = IDLE;
      end
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs and RAM control; burst reads are issued one beat ahead.
  always_comb begin
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_adr  = r_adr;
    w_wr_en   = 1'b0;
    w_adr_nxt = r_adr;
    case (r_state)
      IDLE: begin
        w_adr_nxt = wb_adr_i[AW-1:2];
        w_rd_adr  = wb_adr_i[AW-1:2];
        w_rd_en   = w_req & w_in_range;
      end
      CLASSIC: begin
        wb_ack_o = 1'b1;
        w_wr_en  = wb_we_i;
      end
      BURST: begin
        if (w_req) begin
          wb_ack_o  = 1'b1;
          w_wr_en   = wb_we_i;
          w_adr_nxt = w_inc[WW-1:0];
          w_rd_adr  = w_inc[WW-1:0];
          w_rd_en   = 1'b1;
        end
      end
      ERR:     wb_err_o = 1'b1;
      default: ;
    endcase
  end

  // Current beat word address.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_adr <= '0;
    else             r_adr <= w_adr_nxt;
  end

  wb_ram_burst_mem #(
    .WW      (WW),
    .MEMFILE (MEMFILE)
  ) ram0 (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_n_i),
    .i_rd_en  (w_rd_en),
    .i_rd_adr (w_rd_adr),
    .i_wr_en  (w_wr_en),
    .i_wr_adr (r_adr),
    .i_wr_dat (wb_dat_i),
    .i_wr_sel (wb_sel_i),
    .o_rd_dat (wb_dat_o)
  );

endmodule

// File: tb/tb_wb_ram_burst.sv
// Scoreboard bench for wb_ram_burst: drivers push expected beats, a monitor checks them.
module tb_wb_ram_burst;

  localparam logic [31:0] MEM_SIZE = 32'h02000000;
  localparam int unsigned MEMW     = MEM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  logic [2:0]  cti;
  logic [1:0]  bte;

  typedef enum {K_RD, K_WR, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
    bit          chk;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] model [int unsigned];
  logic [31:0] last_rd;
  bit          last_rd_ok;
  int          vectors, miscompares;

  wb_ram_burst #(.MEM_SIZE(MEM_SIZE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_cti_i   (cti),
    .wb_bte_i   (bte),
    .wb_dat_o   (dat_r),
    .wb_ack_o   (ack),
    .wb_err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Next word of a burst: linear wraps at the memory end, wrapN stays in its aligned block.
  function automatic int unsigned nxt(input int unsigned w, input int unsigned b);
    int unsigned n;
    if (b == 0) return (w + 1) % MEMW;
    n = 4 << (b - 1);
    return (w / n) * n + ((w % n) + 1) % n;
  endfunction

  function automatic logic [31:0] mread(input int unsigned w);
    return model.exists(w) ? model[w] : 32'hxxxxxxxx;
  endfunction

  task automatic classic(input bit w_e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sb_t e;
    int  t;
    int unsigned w;
    w   = a >> 2;
    cyc = 1'b1; stb = 1'b1; we = w_e; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
    if (a >= MEM_SIZE) begin
      e.kind = K_ERR; e.data = last_rd; e.chk = last_rd_ok && !w_e;
    end else if (w_e) begin
      model[w] = merge(mread(w), d, s);
      e.kind = K_WR; e.data = '0; e.chk = 1'b0; last_rd_ok = 1'b0;
    end else begin
      e.kind = K_RD; e.data = mread(w); e.chk = 1'b1;
      last_rd = e.data; last_rd_ok = 1'b1;
    end
    sb.push_back(e);
    #1;
    t = 0;
    while (!(ack || err) && t < 20) begin tick(); t++; end
    if (!(ack || err)) begin
      vectors++; miscompares++;
      $display("FAIL classic_timeout: no ack/err for address %08h", a);
      sb.delete();
    end else tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    chk("classic_ack_gap", {31'd0, ack}, 32'd0);
    chk("classic_err_gap", {31'd0, err}, 32'd0);
  endtask

  task automatic burst(input bit w_e, input int unsigned w0, input int unsigned b, input int n,
                       input int gap_k, input int gap_n, input int rst_k, input bit rnd_sel);
    sb_t e;
    int  t;
    int unsigned w;
    logic [31:0] d;
    logic [3:0]  s;
    w   = w0;
    last_rd_ok = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w_e; adr = w0 << 2; bte = 2'(b);
    for (int k = 0; k < n; k++) begin
      cti   = (k == n - 1) ? 3'b111 : 3'b010;
      d     = $urandom;
      s     = rnd_sel ? 4'($urandom) : 4'hf;
      dat_w = d; sel = s;
      if (k == rst_k) begin
        #1 rst_n = 1'b0;
        #1 chk("reset_async_ack", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        repeat (2) tick();
        rst_n = 1'b1;
        return;
      end
      if (w_e) begin
        model[w] = merge(mread(w), d, s);
        e.kind = K_WR; e.data = '0; e.chk = 1'b0;
      end else begin
        e.kind = K_RD; e.data = mread(w); e.chk = 1'b1;
      end
      sb.push_back(e);
      #1;
      t = 0;
      while (!ack && t < 20) begin tick(); t++; end
      if (!ack) begin
        vectors++; miscompares++;
        $display("FAIL burst_timeout: beat %0d of burst at word %0d", k, w0);
        sb.delete();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        return;
      end
      tick();
      w = nxt(w, b);
      if (k == gap_k) begin
        stb = 1'b0;
        for (int g = 0; g < gap_n; g++) begin
          #1 chk("burst_wait_ack", {31'd0, ack}, 32'd0);
          tick();
        end
        stb = 1'b1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    #1;
    chk("burst_end_ack", {31'd0, ack}, 32'd0);
  endtask

  // Monitor: every ack/err cycle consumes one expected beat.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        vectors++;
        if (ack && err) begin
          miscompares++;
          $display("FAIL ack_err_excl: ack=%0b err=%0b required not both", ack, err);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: ack=%0b err=%0b with empty scoreboard", ack, err);
        end else begin
          e = sb.pop_front();
          if (e.kind == K_ERR) begin
            if (!err) begin
              miscompares++;
              $display("FAIL beat_kind: got ack required err");
            end else if (e.chk && dat_r !== e.data) begin
              miscompares++;
              $display("FAIL err_dat_hold: got %08h required %08h", dat_r, e.data);
            end
          end else if (!ack) begin
            miscompares++;
            $display("FAIL beat_kind: got err required ack");
          end else if (e.kind == K_RD && dat_r !== e.data) begin
            miscompares++;
            $display("FAIL read_data: got %08h required %08h at %0t", dat_r, e.data, $time);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned r, w0, b;
    int n, gk;
    vectors = 0; miscompares = 0; last_rd = '0; last_rd_ok = 1'b0;
    adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_dat", dat_r, 32'd0);
    #19 rst_n = 1'b1;
    tick();

    for (int unsigned i = 0; i < 256; i++) classic(1'b1, i << 2, $urandom, 4'hf);

    classic(1'b1, 32'h100, 32'hDEADBEEF, 4'hf);
    classic(1'b0, 32'h100, '0, 4'hf);
    classic(1'b1, 32'h100, 32'h00AA0000, 4'b0100);
    classic(1'b0, 32'h100, '0, 4'hf);
    chk("byte_lane_model", model[64], 32'hDEAABEEF);

    for (int unsigned i = 0; i < 4; i++) classic(1'b1, (4 + i) << 2, i + 1, 4'hf);
    burst(1'b0, 6, 1, 4, -1, 0, -1, 1'b0);

    burst(1'b1, 128, 0, 8, 2, 2, -1, 1'b0);
    burst(1'b0, 128, 0, 8, -1, 0, -1, 1'b0);

    classic(1'b0, 32'h100, '0, 4'hf);
    classic(1'b0, MEM_SIZE, '0, 4'hf);
    classic(1'b1, MEM_SIZE + 32'h100, 32'h12345678, 4'hf);
    classic(1'b0, 32'h100, '0, 4'hf);

    classic(1'b1, 32'h0, 32'h00000000, 4'b0000);
    classic(1'b0, 32'h0, '0, 4'hf);

    burst(1'b1, MEMW - 2, 0, 4, -1, 0, -1, 1'b0);
    burst(1'b0, MEMW - 2, 0, 4, -1, 0, -1, 1'b0);

    burst(1'b1, 160, 0, 4, -1, 0, 1, 1'b0);
    #1;
    chk("post_reset_ack", {31'd0, ack}, 32'd0);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    chk("post_reset_dat", dat_r, 32'd0);
    tick();
    classic(1'b0, 160 << 2, '0, 4'hf);
    classic(1'b0, 161 << 2, '0, 4'hf);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) classic(1'b0, $urandom_range(0, 255) << 2, '0, 4'hf);
      else if (r == 1) classic(1'b1, $urandom_range(0, 255) << 2, $urandom, 4'($urandom));
      else begin
        w0 = $urandom_range(0, 200);
        b  = $urandom_range(0, 3);
        n  = int'($urandom_range(2, 12));
        gk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
        burst(r == 2, w0, b, n, gk, int'($urandom_range(1, 3)), -1, 1'b1);
      end
    end

    repeat (4) tick();
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
